trap_ctrl: RTL and testbench

//  Sequences ECALL, MRET and external-interrupt entry for the 5-stage pipeline.

---
 rtl/trap_ctrl.sv | 148 ++++++++++++++
 tb/tb_trap_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Trap sequencer for the 5-stage pipeline. Watches the instruction in EX for ECALL
// or MRET, and for an enabled external interrupt. When one is taken it flushes the
// pipeline and holds the PC. If MEM is still busy it waits for MEM to finish. It
// then writes the CSR file for one cycle and redirects the PC for one cycle.
//
// Ports
//   clk, rstn          clock and asynchronous active-low reset
//   ex_*               decoded state of the EX instruction (valid, exception, cause,
//                      mret, pc)
//   mem_busy           an older instruction in MEM has not finished
//   ext_irq            asynchronous level interrupt request
//   csr_mie/mtvec/mepc CSR values read by the sequencer
//   flush_*, stall_pc  pipeline control
//   pc_redirect        one-cycle PC load of redirect_pc
//   csr_trap_we        one-cycle trap write (mepc/mcause wdata valid)
//   csr_mret_we        one-cycle MRET status update
//   busy               a sequence is in progress
module trap_ctrl #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] IRQ_CAUSE   = XLEN'(32'h8000000B),
  parameter int unsigned     SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_valid,
  input  logic            ex_exception,
  input  logic [XLEN-1:0] ex_cause,
  input  logic            ex_mret,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            mem_busy,
  input  logic            ext_irq,
  input  logic            csr_mie,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            flush_ex_mem,
  output logic            stall_pc,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            csr_trap_we,
  output logic [XLEN-1:0] csr_mepc_wdata,
  output logic [XLEN-1:0] csr_mcause_wdata,
  output logic            csr_mret_we,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StDrain, StCommit, StRedirect} state_e;

  state_e            state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              is_mret_q, is_mret_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   cause_q, cause_d;

  logic irq_sync;
  logic evt_exc, evt_mret, evt_irq, evt_any;
  logic flush_all;

  // Only direct-mode vectors are supported, so the mode bits are dropped.
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^csr_mtvec[1:0];

  assign irq_sync = sync_q[SYNC_STAGES-1];

  // Events are gated by rstn so that every output is 0 while reset is held,
  // including the combinational flushes of the IDLE state.
  assign evt_exc  = rstn & ex_valid & ex_exception;
  assign evt_mret = rstn & ex_valid & ex_mret;
  assign evt_irq  = rstn & ex_valid & irq_sync & csr_mie & ~ex_exception & ~ex_mret;
  assign evt_any  = evt_exc | evt_mret | evt_irq;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      is_mret_q <= 1'b0;
      pc_q      <= '0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], ext_irq};
      is_mret_q <= is_mret_d;
      pc_q      <= pc_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    is_mret_d        = is_mret_q;
    pc_d             = pc_q;
    cause_d          = cause_q;
    flush_all        = 1'b0;
    stall_pc         = 1'b0;
    pc_redirect      = 1'b0;
    redirect_pc      = '0;
    csr_trap_we      = 1'b0;
    csr_mepc_wdata   = '0;
    csr_mcause_wdata = '0;
    csr_mret_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (evt_any) begin
          flush_all = 1'b1;
          stall_pc  = 1'b1;
          // Priority exc > mret > irq. An interrupt saves ex_pc so EX re-executes.
          is_mret_d = ~evt_exc & evt_mret;
          pc_d      = ex_pc;
          cause_d   = evt_exc ? ex_cause : (evt_mret ? '0 : IRQ_CAUSE);
          state_d   = mem_busy ? StDrain : StCommit;
        end
      end
      StDrain: begin
        flush_all = 1'b1;
        stall_pc  = 1'b1;
        if (!mem_busy) state_d = StCommit;
      end
      StCommit: begin
        flush_all = 1'b1;
        stall_pc  = 1'b1;
        if (is_mret_q) begin
          csr_mret_we = 1'b1;
        end else begin
          csr_trap_we      = 1'b1;
          csr_mepc_wdata   = pc_q;
          csr_mcause_wdata = cause_q;
        end
        state_d = StRedirect;
      end
      StRedirect: begin
        flush_all   = 1'b1;
        pc_redirect = 1'b1;
        // The MRET target reads csr_mepc live, after any write in COMMIT has landed.
        redirect_pc = is_mret_q ? csr_mepc : {csr_mtvec[XLEN-1:2], 2'b00};
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign flush_if_id  = flush_all;
  assign flush_id_ex  = flush_all;
  assign flush_ex_mem = flush_all;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_exception = 1'b0;
  logic [31:0] ex_cause = '0;
  logic        ex_mret = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        mem_busy = 1'b0;
  logic        ext_irq = 1'b0;
  logic        csr_mie = 1'b0;
  logic [31:0] csr_mtvec = 32'h203;
  logic [31:0] csr_mepc = '0;

  logic        flush_if_id, flush_id_ex, flush_ex_mem, stall_pc, pc_redirect;
  logic [31:0] redirect_pc, csr_mepc_wdata, csr_mcause_wdata;
  logic        csr_trap_we, csr_mret_we, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int trap_cnt = 0;
  int snap;

  // Bit order: flush_if_id flush_id_ex flush_ex_mem stall_pc pc_redirect trap_we mret_we busy
  localparam logic [7:0] CQuiet  = 8'h00;
  localparam logic [7:0] CEvent  = 8'hF0;
  localparam logic [7:0] CDrain  = 8'hF1;
  localparam logic [7:0] CTrap   = 8'hF5;
  localparam logic [7:0] CMret   = 8'hF3;
  localparam logic [7:0] CRedir  = 8'hE9;

  logic [7:0] ctrl_vec;
  assign ctrl_vec = {flush_if_id, flush_id_ex, flush_ex_mem, stall_pc,
                     pc_redirect, csr_trap_we, csr_mret_we, busy};

  trap_ctrl dut (
    .clk              (clk),
    .rstn             (rstn),
    .ex_valid         (ex_valid),
    .ex_exception     (ex_exception),
    .ex_cause         (ex_cause),
    .ex_mret          (ex_mret),
    .ex_pc            (ex_pc),
    .mem_busy         (mem_busy),
    .ext_irq          (ext_irq),
    .csr_mie          (csr_mie),
    .csr_mtvec        (csr_mtvec),
    .csr_mepc         (csr_mepc),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .flush_ex_mem     (flush_ex_mem),
    .stall_pc         (stall_pc),
    .pc_redirect      (pc_redirect),
    .redirect_pc      (redirect_pc),
    .csr_trap_we      (csr_trap_we),
    .csr_mepc_wdata   (csr_mepc_wdata),
    .csr_mcause_wdata (csr_mcause_wdata),
    .csr_mret_we      (csr_mret_we),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (csr_trap_we) trap_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] ctrl, input logic [31:0] rpc,
                          input logic [31:0] mepc, input logic [31:0] mcause);
    check({tag, ".ctrl"}, {24'h0, ctrl_vec}, {24'h0, ctrl});
    check({tag, ".rpc"}, redirect_pc, rpc);
    check({tag, ".mepc"}, csr_mepc_wdata, mepc);
    check({tag, ".mcause"}, csr_mcause_wdata, mcause);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    ex_valid     = 1'b0;
    ex_exception = 1'b0;
    ex_mret      = 1'b0;
    mem_busy     = 1'b0;
  endtask

  task automatic ecall(input logic [31:0] pc, input logic [31:0] cause, input logic mb);
    ex_valid     = 1'b1;
    ex_exception = 1'b1;
    ex_mret      = 1'b0;
    ex_pc        = pc;
    ex_cause     = cause;
    mem_busy     = mb;
  endtask

  initial begin
    // Reset
    #1 rstn = 1'b0;
    #2 chk_outs("rst", CQuiet, 0, 0, 0);
    cyc; cyc;
    rstn = 1'b1;
    #1 chk_outs("post_rst", CQuiet, 0, 0, 0);
    cyc;

    // 1: ECALL, no drain
    ecall(32'h100, 32'd11, 1'b0);
    #1 chk_outs("t1.n", CEvent, 0, 0, 0);
    cyc; clear_in;
    #1 chk_outs("t1.n1", CTrap, 0, 32'h100, 32'd11);
    cyc;
    #1 chk_outs("t1.n2", CRedir, 32'h200, 0, 0);
    cyc;
    #1 chk_outs("t1.n3", CQuiet, 0, 0, 0);
    cyc;

    // 2: MRET
    csr_mepc = 32'h104;
    ex_valid = 1'b1; ex_mret = 1'b1; ex_pc = 32'h180;
    #1 chk_outs("t2.n", CEvent, 0, 0, 0);
    cyc; clear_in;
    #1 chk_outs("t2.n1", CMret, 0, 0, 0);
    cyc;
    #1 chk_outs("t2.n2", CRedir, 32'h104, 0, 0);
    cyc;
    #1 chk_outs("t2.n3", CQuiet, 0, 0, 0);
    cyc;

    // 3: ECALL with MEM busy for N..N+2
    ecall(32'h100, 32'd11, 1'b1);
    #1 chk_outs("t3.n", CEvent, 0, 0, 0);
    cyc; ex_valid = 1'b0; ex_exception = 1'b0;
    #1 chk_outs("t3.n1", CDrain, 0, 0, 0);
    cyc;
    #1 chk_outs("t3.n2", CDrain, 0, 0, 0);
    cyc; mem_busy = 1'b0;
    #1 chk_outs("t3.n3", CDrain, 0, 0, 0);
    cyc;
    #1 chk_outs("t3.n4", CTrap, 0, 32'h100, 32'd11);
    cyc;
    #1 chk_outs("t3.n5", CRedir, 32'h200, 0, 0);
    cyc;
    #1 chk_outs("t3.n6", CQuiet, 0, 0, 0);
    cyc;

    // 4: external interrupt through the synchroniser
    ext_irq = 1'b1; csr_mie = 1'b1; ex_valid = 1'b1; ex_pc = 32'h40;
    #1 chk_outs("t4.a0", CQuiet, 0, 0, 0);
    cyc;
    #1 chk_outs("t4.a1", CQuiet, 0, 0, 0);
    cyc;
    #1 chk_outs("t4.n", CEvent, 0, 0, 0);
    cyc;
    #1 chk_outs("t4.n1", CTrap, 0, 32'h40, 32'h8000000B);
    cyc;
    #1 chk_outs("t4.n2", CRedir, 32'h200, 0, 0);
    cyc; ex_valid = 1'b0;
    #1 chk_outs("t4.novalid", CQuiet, 0, 0, 0);
    cyc; ex_valid = 1'b1; csr_mie = 1'b0;
    #1 chk_outs("t4.nomie0", CQuiet, 0, 0, 0);
    cyc;
    #1 chk_outs("t4.nomie1", CQuiet, 0, 0, 0);
    cyc;

    // 5: ECALL and interrupt together; second ECALL while busy is ignored
    csr_mie = 1'b1;
    snap = trap_cnt;
    ecall(32'h100, 32'd11, 1'b0);
    #1 chk_outs("t5.n", CEvent, 0, 0, 0);
    cyc; ex_pc = 32'h300; ex_cause = 32'd2;
    #1 chk_outs("t5.n1", CTrap, 0, 32'h100, 32'd11);
    cyc;
    #1 chk_outs("t5.n2", CRedir, 32'h200, 0, 0);
    cyc; clear_in; ext_irq = 1'b0;
    #1 chk_outs("t5.n3", CQuiet, 0, 0, 0);
    check("t5.one_trap", trap_cnt - snap, 1);
    cyc; cyc; cyc;

    // 6: reset during DRAIN aborts the sequence
    snap = trap_cnt;
    ecall(32'h100, 32'd11, 1'b1);
    #1 chk_outs("t6.n", CEvent, 0, 0, 0);
    cyc;
    #1 chk_outs("t6.drain", CDrain, 0, 0, 0);
    rstn = 1'b0;
    #1 chk_outs("t6.rst", CQuiet, 0, 0, 0);
    cyc; cyc;
    clear_in; rstn = 1'b1;
    #1 chk_outs("t6.rel0", CQuiet, 0, 0, 0);
    cyc;
    #1 chk_outs("t6.rel1", CQuiet, 0, 0, 0);
    cyc;
    #1 check("t6.no_strobe", trap_cnt - snap, 0);
    ecall(32'h120, 32'd11, 1'b0);
    #1 chk_outs("t6.m", CEvent, 0, 0, 0);
    cyc; clear_in;
    #1 chk_outs("t6.m1", CTrap, 0, 32'h120, 32'd11);
    cyc;
    #1 chk_outs("t6.m2", CRedir, 32'h200, 0, 0);
    cyc;
    #1 chk_outs("t6.m3", CQuiet, 0, 0, 0);
    cyc;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
